// File: rtl/prim_rr_onehot_arb.sv
// ---------------------------------------------------------------------------
// prim_rr_onehot_arb
//
// Registered round-robin arbiter. It produces the one-hot select for a
// downstream one-hot mux. The grant is registered and locked for the whole
// valid/ready transfer, so the mux select stays glitch-free and constant
// while the consumer holds off.
//
// Parameters
//   N     number of requesters (>= 1)
//   IdxW  width of idx_o; derived from N, do not override
//
// Ports
//   clk_i    in   1     clock, rising edge
//   rst_i    in   1     asynchronous active-high reset
//   req_i    in   N     request vector, bit i = requester i wants a grant
//   ready_i  in   1     consumer accepts the presented grant
//   gnt_o    out  N     registered one-hot grant, zero when valid_o = 0
//   idx_o    out  IdxW  binary index of the granted requester, 0 when idle
//   valid_o  out  1     a grant is being presented
// ---------------------------------------------------------------------------
module prim_rr_onehot_arb #(
    parameter int N    = 8,
    parameter int IdxW = N > 1 ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_i,
    input  logic            ready_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] ptr_inc;
    logic [IdxW-1:0] search_ptr;
    logic [IdxW-1:0] win_idx;
    logic [N-1:0]    win_oh;
    logic            handshake;

    assign handshake = (state_q == GRANT) && ready_i;

    // Pointer after the current grant retires: one past the granted index,
    // wrapping at N (not at 2**IdxW) so non-power-of-2 N stays in range.
    assign ptr_inc = (idx_q == IdxW'(N - 1)) ? '0 : idx_q + IdxW'(1);

    // On a handshake the pointer update must take effect before the search,
    // so the search starts from the post-update value rather than ptr_q.
    assign search_ptr = handshake ? ptr_inc : ptr_q;

    // Two-pass priority search folded into one loop: scanning downward, the
    // last hit in each half is the lowest index. The upper half (i >= ptr)
    // wins if it has any request; otherwise the wrapped lower half is used.
    logic            found_hi;
    logic [IdxW-1:0] idx_hi;
    logic [IdxW-1:0] idx_lo;

    always_comb begin
        // NOTE: every combinationally assigned variable gets a default before
        // any conditional logic, otherwise synthesis infers a latch.
        found_hi = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                if (i >= int'(search_ptr)) begin
                    found_hi = 1'b1;
                    idx_hi   = IdxW'(i);
                end else begin
                    idx_lo = IdxW'(i);
                end
            end
        end
        win_idx = found_hi ? idx_hi : idx_lo;
        for (int i = 0; i < N; i++) begin
            win_oh[i] = (win_idx == IdxW'(i));
        end
    end

    // Next-state and next-output logic. Outputs are registered, so nothing
    // here reaches a port without passing through a flop.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                // ready_i is deliberately ignored here: nothing is presented.
                if (|req_i) begin
                    state_d = GRANT;
                    gnt_d   = win_oh;
                    idx_d   = win_idx;
                end
            end
            GRANT: begin
                // Without ready_i the grant is locked, even if the granted
                // request drops, so the defaults already hold everything.
                if (ready_i) begin
                    ptr_d = ptr_inc;
                    if (|req_i) begin
                        gnt_d = win_oh;
                        idx_d = win_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values, independent of statement order.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign idx_o   = idx_q;
    assign valid_o = (state_q == GRANT);

endmodule

// File: tb/tb_prim_rr_onehot_arb.sv
// ---------------------------------------------------------------------------
// tb_prim_rr_onehot_arb
//
// Scoreboard bench for prim_rr_onehot_arb with an N=8 and an N=5 instance.
// Stimulus pushes the hand-computed index expected at each handshake into a
// per-instance queue; a monitor per instance pops and compares whenever the
// DUT presents a grant that the consumer accepts. Held grants, reset values
// and idle return are checked directly by the stimulus thread.
// ---------------------------------------------------------------------------
module tb_prim_rr_onehot_arb;

    logic       clk = 1'b0;
    logic       rst_i;

    logic [7:0] req8;
    logic       ready8;
    logic [7:0] gnt8;
    logic [2:0] idx8;
    logic       valid8;

    logic [4:0] req5;
    logic       ready5;
    logic [4:0] gnt5;
    logic [2:0] idx5;
    logic       valid5;

    int checks   = 0;
    int failures = 0;
    int q8[$];
    int q5[$];

    always #5 clk = ~clk;

    prim_rr_onehot_arb #(.N(8)) dut8 (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .req_i   (req8),
        .ready_i (ready8),
        .gnt_o   (gnt8),
        .idx_o   (idx8),
        .valid_o (valid8)
    );

    prim_rr_onehot_arb #(.N(5)) dut5 (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .req_i   (req5),
        .ready_i (ready5),
        .gnt_o   (gnt5),
        .idx_o   (idx5),
        .valid_o (valid5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors sample on the falling edge, away from the active edge. A grant
    // with ready high at this point will be consumed at the next rising edge.
    always @(negedge clk) begin : mon8
        int e;
        if (!rst_i && valid8 && ready8) begin
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb8_unexpected: got idx %0d expected no handshake at %0t", idx8, $time);
            end else begin
                e = q8.pop_front();
                check("sb8_idx", 32'(idx8), 32'(e));
                check("sb8_gnt", 32'(gnt8), 32'(1) << e);
            end
        end
    end

    always @(negedge clk) begin : mon5
        int e;
        if (!rst_i && valid5 && ready5) begin
            if (q5.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb5_unexpected: got idx %0d expected no handshake at %0t", idx5, $time);
            end else begin
                e = q5.pop_front();
                check("sb5_idx", 32'(idx5), 32'(e));
                check("sb5_gnt", 32'(gnt5), 32'(1) << e);
            end
        end
    end

    // Drive the N=8 instance for one clock; returns 2 time units after the edge.
    task automatic cycle8(input logic [7:0] req, input logic rdy);
        req8   = req;
        ready8 = rdy;
        @(posedge clk);
        #2;
    endtask

    // Asserts reset away from any edge, checks the outputs clear with no
    // clock edge in between, then releases reset just after a rising edge.
    task automatic do_reset();
        req8   = '0;
        ready8 = 1'b0;
        req5   = '0;
        ready5 = 1'b0;
        rst_i  = 1'b1;
        #1;
        check("rst_gnt8", 32'(gnt8), 32'h0);
        check("rst_idx8", 32'(idx8), 32'h0);
        check("rst_valid8", 32'(valid8), 32'h0);
        check("rst_valid5", 32'(valid5), 32'h0);
        @(posedge clk);
        #2;
        rst_i = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_i  = 1'b0;
        req8   = '0;
        ready8 = 1'b0;
        req5   = '0;
        ready5 = 1'b0;
        #1;
        do_reset();

        // Reset mid-grant, then a fresh grant from pointer 0.
        cycle8(8'h04, 1'b0);
        check("a_gnt_04", 32'(gnt8), 32'h04);
        check("a_idx_2", 32'(idx8), 32'd2);
        do_reset();
        cycle8(8'h01, 1'b0);
        check("a_gnt_01", 32'(gnt8), 32'h01);
        q8.push_back(0);
        cycle8(8'h00, 1'b1);
        check("a_idle", 32'(valid8), 32'h0);

        // Full rotation: all requesting, consumer always ready.
        do_reset();
        for (int i = 0; i < 8; i++) q8.push_back(i);
        q8.push_back(0);
        for (int i = 0; i < 10; i++) cycle8(8'hFF, 1'b1);

        // Grant locked under backpressure while requests change.
        do_reset();
        cycle8(8'h0A, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle8(8'h08, 1'b0);
            check("c_hold_gnt", 32'(gnt8), 32'h02);
            check("c_hold_valid", 32'(valid8), 32'h1);
        end
        q8.push_back(1);
        q8.push_back(3);
        cycle8(8'h08, 1'b1);
        check("c_next_gnt", 32'(gnt8), 32'h08);
        cycle8(8'h00, 1'b1);

        // Wrap and skip: handshake idx 5 puts the pointer at 6.
        do_reset();
        cycle8(8'h20, 1'b0);
        q8.push_back(5);
        cycle8(8'h21, 1'b1);
        check("d_wrap_idx", 32'(idx8), 32'd0);
        q8.push_back(0);
        cycle8(8'h21, 1'b1);
        check("d_skip_idx", 32'(idx8), 32'd5);
        q8.push_back(5);
        cycle8(8'h00, 1'b1);

        // Single persistent requester, then return to idle; ready while idle
        // must not start anything.
        do_reset();
        q8.push_back(4);
        q8.push_back(4);
        q8.push_back(4);
        for (int i = 0; i < 3; i++) begin
            cycle8(8'h10, 1'b1);
            check("e_single_idx", 32'(idx8), 32'd4);
        end
        cycle8(8'h00, 1'b1);
        check("e_idle_valid", 32'(valid8), 32'h0);
        cycle8(8'h00, 1'b1);
        check("e_idle_gnt", 32'(gnt8), 32'h0);

        // Non-power-of-2 rotation on the N=5 instance.
        do_reset();
        for (int i = 0; i < 5; i++) q5.push_back(i);
        q5.push_back(0);
        req5   = 5'h1F;
        ready5 = 1'b1;
        repeat (7) begin
            @(posedge clk);
            #2;
        end
        ready5 = 1'b0;
        check("f_held_idx", 32'(idx5), 32'd1);
        req5 = '0;

        repeat (2) @(posedge clk);
        #2;
        check("sb8_drain", 32'(q8.size()), 32'd0);
        check("sb5_drain", 32'(q5.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prim_rr_onehot_arb.md
# prim_rr_onehot_arb

Registered round-robin arbiter producing the one-hot select vector that drives the `sel_i` input of the downstream one-hot mux. Up to `N` requesters assert `req_i`, and the block picks one fairly. It presents the winner as a stable one-hot `gnt_o` plus a binary index, and holds that grant through a valid/ready handshake with the consumer. Because the grant is registered, the mux select is glitch-free and constant for the whole transfer.

## Interface
- `N`, default 8: number of requesters; must be ≥ 1.
- `IdxW`, default `N > 1 ? $clog2(N) : 1`: width of `idx_o`. Derived; do not override.

- `clk_i`  in  1  clock. Everything is rising-edge.
- `rst_i`  in  1  reset. One clock; reset is asynchronous and active-high.
- `req_i`  in  `N`  request vector. Bit i means requester i wants a grant.
- `gnt_o`  out  `N`  registered one-hot grant; all-zero when `valid_o`=0. Connects to the mux `sel_i`.
- `idx_o`  out  `IdxW`  binary index of the granted requester; 0 when `valid_o`=0.
- `valid_o`  out  1  a grant is being presented.
- `ready_i`  in  1  consumer accepts the current grant.

## Operation
- State is 2-state FSM {IDLE, GRANT} plus a round-robin pointer `ptr` in the range 0..N-1.
- Winner selection: the lowest index i ≥ `ptr` with `req_i[i]`=1. If none exists, wrap and take the lowest i < `ptr` with `req_i[i]`=1. For non-power-of-2 `N`, the search covers indices 0..N-1 only.
- **IDLE**
  - If `req_i` ≠ 0: register the winner into `gnt_o`/`idx_o`, set `valid_o`=1, go to GRANT.
  - Otherwise stay in IDLE with outputs at zero.
- **GRANT**
  - While `ready_i`=0: `gnt_o`, `idx_o` and `valid_o` hold unchanged. This applies even if `req_i` changes, including the granted bit dropping. The grant is locked.
  - When `ready_i`=1 (handshake):
    - `ptr` ← `(idx_o + 1) mod N`.
    - If `req_i` ≠ 0 in that cycle, load the next winner immediately, searched from the updated pointer. Stay in GRANT with `valid_o`=1, giving back-to-back grants and full throughput.
    - Otherwise clear the outputs and go to IDLE.
- A single persistent requester is re-granted every cycle while `ready_i`=1.
- Fairness: with all N requesting continuously and `ready_i`=1, each requester is granted exactly once every N cycles.
- Invariants: `gnt_o` is one-hot or zero; `gnt_o[idx_o]` = `valid_o`; `valid_o` equals (state == GRANT).
- `N`=1: `ptr` is constant 0, and `idx_o` is 1 bit and always 0.

## Timing
- Reset (async assert, released synchronously by the system): state = IDLE, `ptr`=0, `gnt_o`=0, `idx_o`=0, `valid_o`=0.
- Asserting `rst_i` mid-grant clears the outputs immediately without waiting for a clock edge. The pending transfer is abandoned and `ptr` returns to 0.
- Latency:
  - `req_i` asserted at edge k with the block in IDLE → `valid_o`/`gnt_o` visible after edge k+1.
  - Handshake at edge k → next grant visible after edge k, with no bubble.
- Outputs are purely registered. There is no combinational path from `req_i` or `ready_i` to any output.
- `ready_i` is ignored while `valid_o`=0.
- If `req_i` and the handshake arrive in the same cycle, the new request competes in the same arbitration as the existing ones. The pointer update takes effect before the search.

## Test plan
- **Reset values:** assert `rst_i` mid-GRANT with `gnt_o`=8'h04 → `gnt_o`=0, `valid_o`=0, `idx_o`=0 with no clock edge. After release, `req_i`=8'h01 → `gnt_o`=8'h01 one cycle later.
- **Full rotation:** N=8, `req_i`=8'hFF, `ready_i`=1 → `idx_o` sequence 0,1,2,…,7,0 on consecutive cycles, and `gnt_o` always one-hot.
- **Lock under backpressure:** `req_i`=8'h0A, `ready_i`=0 → `gnt_o`=8'h02 held for 5 cycles even after `req_i` changes to 8'h08. Then `ready_i`=1 → next `gnt_o`=8'h08.
- **Wrap and skip:** set `ptr`=6 by handshaking `idx_o`=5, then `req_i`=8'h21 → `idx_o`=0. Next handshake → `idx_o`=5.
- **Single requester and idle return:** `req_i`=8'h10 with `ready_i`=1 for 3 cycles → `idx_o`=4 every cycle. Then `req_i`=0 at a handshake → `valid_o`=0 the next cycle.
- **Non-power-of-2:** N=5, `req_i`=5'h1F, `ready_i`=1 → `idx_o` sequence 0,1,2,3,4,0, and `idx_o` never reaches 5–7.
